// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
package uart_tx_arbiter_pkg;

    // Frame sequencer states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_t;

    localparam int unsigned UartOversample = 16;
    localparam int unsigned UartDataW      = 8;
    // Width of requester indices (grant_id, rr_ptr); covers up to 8 requesters.
    localparam int unsigned IdxW           = 3;

    // Round-robin pointer advance: index after idx, wrapping at num_req.
    function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx,
                                                input int unsigned     num_req);
        if (32'(idx) + 32'd1 >= num_req) begin
            return '0;
        end
        return idx + IdxW'(1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/acknowledge bundle between the byte requesters and the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        ack;

    // Requester side: raises req with a stable byte, waits for ack.
    modport master (
        output req,
        output data_in,
        input  ack
    );

    // Arbiter side: samples requests, pulses ack when the byte is latched.
    modport slave (
        input  req,
        input  data_in,
        output ack
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
// Kept free of state so it can be reused by other arbiters.
module uart_tx_arbiter_rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IdxW-1:0]    gnt_idx
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic            found;
    logic [PtrW-1:0] cand;

    // Scan requests starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = PtrW'((int'(ptr) + i) % int'(NUM_REQ));
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmit line between NUM_REQ requesters, round-robin,
// one byte per grant. Bit timing comes from a 16x oversample strobe.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = UartDataW,
    parameter int unsigned OVERSAMPLE = UartOversample
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    uart_tx_arbiter_if.slave     bus,
    output logic [IdxW-1:0]      grant_id,
    output logic                 busy,
    output logic                 tx
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_W);

    uart_state_t         state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                tx_q, tx_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic [DATA_W-1:0]   win_byte;
    logic                tick_last;
    logic                bit_last;

    uart_tx_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign tick_last = (tick_cnt_q == TickW'(OVERSAMPLE - 1));
    assign bit_last  = (bit_cnt_q == BitW'(DATA_W - 1));

    // One-hot select of the winning requester's byte.
    always_comb begin
        win_byte = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_gnt[i]) begin
                win_byte = win_byte | bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame sequencer: arbitration in idle, then start/data/stop bit timing.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ack_d      = '0;
        tx_d       = 1'b1;

        case (state_q)
            StIdle: begin
                // A strobe coinciding with the grant is deliberately not counted.
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (|bus.req) begin
                    ack_d      = arb_gnt;
                    grant_id_d = arb_idx;
                    busy_d     = 1'b1;
                    rr_ptr_d   = rr_next(arb_idx, NUM_REQ);
                    shift_d    = win_byte;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_last) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                busy_d     = 1'b0;
            end
        endcase

        // Line level follows the next state so tx switches on the same edge as the FSM.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.ack  = ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: framing, round-robin order, reset abort, tick phase.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    // Shortened strobe divider; the design only counts strobes, so 4 clk stands in for 321.
    localparam int          TICK_DIV    = 4;
    localparam int          FRAME_TICKS = 160;
    localparam int          FRAME_LIMIT = FRAME_TICKS * TICK_DIV + 64;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic [2:0] grant_id;
    logic       busy;
    logic       tx;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tick   (s_tick),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running oversample strobe generator.
    logic [7:0] div_cnt = '0;
    always @(posedge clk) begin
        if (div_cnt == 8'(TICK_DIV - 1)) div_cnt <= '0;
        else                             div_cnt <= div_cnt + 8'd1;
    end
    assign s_tick = (div_cnt == 8'(TICK_DIV - 1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound, input string name);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (bus.ack == '0 && cyc < bound);
        checks++;
        if (bus.ack === '0) begin
            failures++;
            $display("FAIL %s: ack=%b after %0d clk, required a nonzero ack", name, bus.ack, bound);
        end
    endtask

    // Entered just after the grant edge; follows the whole frame to the busy-fall edge.
    task automatic do_frame(input string name, input int exp_id, input logic [7:0] exp_byte,
                            input logic [NUM_REQ-1:0] raise_mask, input int raise_tick,
                            input int drop_tick);
        logic [9:0]         exp_frame;
        logic [9:0]         got;
        logic [NUM_REQ-1:0] exp_ack;
        logic               cur;
        int                 n;
        int                 cyc;
        bit                 bad_bit;
        bit                 bad_hold;
        exp_frame = {1'b1, exp_byte, 1'b0};
        exp_ack   = NUM_REQ'(1) << exp_id;
        got = '0; cur = 1'b0; n = 0; cyc = 0; bad_bit = 1'b0; bad_hold = 1'b0;

        checks++;
        if (bus.ack !== exp_ack) begin
            failures++;
            $display("FAIL %s_ack: ack=%b, required %b", name, bus.ack, exp_ack);
        end
        checks++;
        if (grant_id !== 3'(exp_id)) begin
            failures++;
            $display("FAIL %s_grant_id: grant_id=%0d, required %0d", name, grant_id, exp_id);
        end
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: busy=%b tx=%b, required busy=1 tx=0", name, busy, tx);
        end

        while (n < FRAME_TICKS && cyc < FRAME_LIMIT) begin
            if (s_tick) begin
                if (n == raise_tick) bus.req = bus.req | raise_mask;
                if (n == drop_tick)  bus.req = bus.req & ~raise_mask;
                if (n % 16 == 0) begin
                    cur = tx;
                    got = {tx, got[9:1]};
                end else if (tx !== cur) begin
                    bad_bit = 1'b1;
                end
                n++;
            end
            step();
            cyc++;
            if (n < FRAME_TICKS &&
                (busy !== 1'b1 || bus.ack !== '0 || grant_id !== 3'(exp_id))) begin
                bad_hold = 1'b1;
            end
        end

        checks++;
        if (n != FRAME_TICKS) begin
            failures++;
            $display("FAIL %s_timeout: %0d ticks seen, required %0d", name, n, FRAME_TICKS);
        end
        checks++;
        if (got !== exp_frame) begin
            failures++;
            $display("FAIL %s_frame: bits=%b, required %b (lsb=start)", name, got, exp_frame);
        end
        checks++;
        if (bad_bit) begin
            failures++;
            $display("FAIL %s_bit_len: tx changed inside a 16-tick bit, required 1 got 0", name);
        end
        checks++;
        if (bad_hold) begin
            failures++;
            $display("FAIL %s_hold: busy/ack/grant_id disturbed mid-frame, required stable", name);
        end
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL %s_end: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.data_in = '0;
        step();
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.ack !== '0 || grant_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_values: tx=%b busy=%b ack=%b grant_id=%0d, required 1 0 0000 0",
                     tx, busy, bus.ack, grant_id);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_single();
        bus.data_in = {8'h44, 8'h33, 8'h22, 8'hA5};
        bus.req     = 4'b0001;
        wait_grant(1, "single_ack_latency");
        bus.req = '0;
        do_frame("single", 0, 8'hA5, '0, -1, -1);
    endtask

    task automatic test_all_held();
        int         exp_id [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_b  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            // One clk after busy falls the next grant must already be there.
            wait_grant(1, "all_held_back_to_back");
            if (k == 4) bus.req = '0;
            do_frame("all_held", exp_id[k], exp_b[k], '0, -1, -1);
        end
    endtask

    task automatic test_rr_wrap();
        bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req     = 4'b1000;
        wait_grant(1, "wrap_last3");
        bus.req = '0;
        do_frame("wrap_last3", 3, 8'h44, '0, -1, -1);
        bus.req = 4'b1001;
        wait_grant(1, "wrap_to0");
        // Requester 1 arrives mid-frame and must wait for the stop bit.
        do_frame("wrap_to0", 0, 8'h11, 4'b0010, 40, -1);
        wait_grant(1, "wrap_ptr1");
        bus.req = '0;
        do_frame("wrap_ptr1", 1, 8'h22, '0, -1, -1);
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        bus.data_in = {8'h44, 8'h33, 8'h2C, 8'h5A};
        bus.req     = 4'b0010;
        wait_grant(1, "midrst_grant");
        checks++;
        if (bus.ack !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_ack: ack=%b, required 0010", bus.ack);
        end
        bus.req = '0;
        n = 0;
        cyc = 0;
        while (n < 88 && cyc < FRAME_LIMIT) begin
            if (s_tick) n++;
            step();
            cyc++;
        end
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_bit4: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.ack !== '0 || grant_id !== 3'd0) begin
            failures++;
            $display("FAIL midrst_abort: tx=%b busy=%b ack=%b grant_id=%0d, required 1 0 0000 0",
                     tx, busy, bus.ack, grant_id);
        end
        rst_n   = 1'b1;
        bus.req = 4'b0101;
        wait_grant(1, "midrst_release");
        bus.req = '0;
        // Winner 0 over 2 shows the pointer went back to 0.
        do_frame("midrst_after", 0, 8'h5A, '0, -1, -1);
    endtask

    task automatic test_tick_coincident();
        int cyc;
        bus.data_in = {8'h44, 8'hC3, 8'h2C, 8'h5A};
        cyc = 0;
        while (s_tick !== 1'b1 && cyc < 4 * TICK_DIV) begin
            step();
            cyc++;
        end
        checks++;
        if (s_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_align: s_tick=%b, required 1", s_tick);
        end
        bus.req = 4'b0100;
        wait_grant(1, "tick_grant");
        bus.req = '0;
        do_frame("tick_coincident", 2, 8'hC3, '0, -1, -1);
    endtask

    task automatic test_withdrawn();
        bit bad;
        bus.data_in = {8'h44, 8'hC3, 8'h2C, 8'h5A};
        bus.req     = 4'b0001;
        wait_grant(1, "withdraw_grant");
        bus.req = '0;
        do_frame("withdraw", 0, 8'h5A, 4'b0100, 40, 50);
        bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (bus.ack !== '0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL withdraw_idle: ack=%b busy=%b tx=%b, required line idle with no ack",
                     bus.ack, busy, tx);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        test_reset();
        test_single();
        test_all_held();
        test_rr_wrap();
        test_reset_mid();
        test_tick_coincident();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
